// File: rtl/ad9833_seq_tx_pkg.sv
// Shared types and helpers for the AD9833-class multi-word serial transmitter.
package ad9833_seq_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP,
        ST_DONE
    } tx_state_t;

    // Width of a down-counter able to hold the largest of three phase lengths.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ad9833_seq_tx_if.sv
// Request/handshake and DDS pin bundle between the waveform controller and the transmitter.
interface ad9833_seq_tx_if #(
    parameter int WORD_W    = 16,
    parameter int MAX_WORDS = 4
) ();
    localparam int NW_W = $clog2(MAX_WORDS + 1);

    logic                        start;
    logic [NW_W-1:0]             num_words;
    logic [MAX_WORDS*WORD_W-1:0] words;
    logic                        abort;
    logic                        busy;
    logic                        done;
    logic                        word_done;
    logic                        fsync;
    logic                        sclk;
    logic                        sdata;

    modport master (
        output start, num_words, words, abort,
        input  busy, done, word_done, fsync, sclk, sdata
    );

    modport slave (
        input  start, num_words, words, abort,
        output busy, done, word_done, fsync, sclk, sdata
    );
endinterface

// File: rtl/ad9833_seq_tx_ser_bit_timer.sv
// Phase timer: loadable down-counter that parks at zero; end_tick marks the last cycle of a phase.
module ser_bit_timer #(
    parameter int CNT_W    = 5,
    parameter int HALF_VAL = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             half_tick,
    output logic             end_tick
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A phase of N cycles is loaded with N-1, so the count equals HALF_VAL
    // exactly one cycle before the second half of a bit period begins.
    assign end_tick  = (cnt == '0);
    assign half_tick = (cnt == CNT_W'(HALF_VAL));
endmodule

// File: rtl/ad9833_seq_tx.sv
// Burst transmitter for AD9833-class DDS parts: 1..MAX_WORDS words, MSB first,
// each framed by its own FSYNC low window.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | pins parked, waiting for start
// ST_LEAD  | busy, fsync/sclk high for one bit period before the first frame
// ST_SETUP | fsync low, sclk high, FSYNC-to-SCLK setup time
// ST_SHIFT | shifting the current word, one bit per CLKS_PER_BIT cycles
// ST_GAP   | fsync high between words and after the last word
// ST_DONE  | one cycle before the done pulse; burst finished
module ad9833_seq_tx
    import ad9833_seq_tx_pkg::*;
#(
    parameter int WORD_W       = 16,
    parameter int MAX_WORDS    = 4,
    parameter int CLKS_PER_BIT = 10,
    parameter int SETUP_CLKS   = 5,
    parameter int GAP_CLKS     = 20
) (
    input  logic           clk,
    input  logic           rst_n,
    ad9833_seq_tx_if.slave bus
);
    localparam int NW_W  = $clog2(MAX_WORDS + 1);
    localparam int BIT_W = $clog2(WORD_W + 1);
    localparam int CNT_W = cnt_width(CLKS_PER_BIT, SETUP_CLKS, GAP_CLKS);

    localparam logic [CNT_W-1:0] LD_BIT   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CLKS - 1);
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(GAP_CLKS - 1);
    localparam logic [NW_W-1:0]  MAX_NW   = NW_W'(MAX_WORDS);

    tx_state_t                   state, state_nx;
    logic [MAX_WORDS*WORD_W-1:0] words_q, words_nx;
    logic [NW_W-1:0]             nw_q, nw_nx, nw_in;
    logic [NW_W-1:0]             widx_q, widx_nx;
    logic [BIT_W-1:0]            bidx_q, bidx_nx;
    logic [WORD_W-1:0]           sr_q, sr_nx, cur_word;
    logic                        fsync_q, fsync_nx;
    logic                        sclk_q, sclk_nx;
    logic                        sdata_q, sdata_nx;
    logic                        busy_q, busy_nx;
    logic                        done_q, done_nx;
    logic                        wdone_q, wdone_nx;
    logic                        tmr_load;
    logic [CNT_W-1:0]            tmr_val;
    logic                        half_tick, end_tick;

    ser_bit_timer #(
        .CNT_W   (CNT_W),
        .HALF_VAL(CLKS_PER_BIT / 2)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .half_tick(half_tick),
        .end_tick (end_tick)
    );

    assign nw_in    = (bus.num_words > MAX_NW) ? MAX_NW : bus.num_words;
    assign cur_word = words_q[int'(widx_q)*WORD_W +: WORD_W];

    always_comb begin
        state_nx = state;
        words_nx = words_q;
        nw_nx    = nw_q;
        widx_nx  = widx_q;
        bidx_nx  = bidx_q;
        sr_nx    = sr_q;
        fsync_nx = fsync_q;
        sclk_nx  = sclk_q;
        sdata_nx = sdata_q;
        busy_nx  = busy_q;
        done_nx  = 1'b0;
        wdone_nx = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;

        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    words_nx = bus.words;
                    nw_nx    = nw_in;
                    widx_nx  = '0;
                    bidx_nx  = '0;
                    if (nw_in == '0) begin
                        state_nx = ST_DONE;
                    end else begin
                        busy_nx  = 1'b1;
                        state_nx = ST_LEAD;
                        tmr_load = 1'b1;
                        tmr_val  = LD_BIT;
                    end
                end
            end
            ST_LEAD: begin
                if (end_tick) begin
                    fsync_nx = 1'b0;
                    state_nx = ST_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (end_tick) begin
                    sdata_nx = cur_word[WORD_W-1];
                    sr_nx    = cur_word << 1;
                    bidx_nx  = BIT_W'(WORD_W - 1);
                    state_nx = ST_SHIFT;
                    tmr_load = 1'b1;
                    tmr_val  = LD_BIT;
                end
            end
            ST_SHIFT: begin
                if (end_tick) begin
                    sclk_nx  = 1'b1;
                    tmr_load = 1'b1;
                    if (bidx_q == '0) begin
                        wdone_nx = 1'b1;
                        fsync_nx = 1'b1;
                        sdata_nx = 1'b0;
                        state_nx = ST_GAP;
                        tmr_val  = LD_GAP;
                    end else begin
                        bidx_nx  = bidx_q - 1'b1;
                        sdata_nx = sr_q[WORD_W-1];
                        sr_nx    = sr_q << 1;
                        tmr_val  = LD_BIT;
                    end
                end else if (half_tick) begin
                    sclk_nx = 1'b0;
                end
            end
            ST_GAP: begin
                if (end_tick) begin
                    if ((widx_q + NW_W'(1)) < nw_q) begin
                        widx_nx  = widx_q + NW_W'(1);
                        fsync_nx = 1'b0;
                        state_nx = ST_SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = LD_SETUP;
                    end else begin
                        state_nx = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_nx  = 1'b1;
                busy_nx  = 1'b0;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase

        // Abort drops the frame on the spot; DONE is already committed and runs out.
        if (bus.abort && (state != ST_IDLE) && (state != ST_DONE)) begin
            state_nx = ST_IDLE;
            fsync_nx = 1'b1;
            sclk_nx  = 1'b1;
            sdata_nx = 1'b0;
            busy_nx  = 1'b0;
            done_nx  = 1'b0;
            wdone_nx = 1'b0;
            widx_nx  = '0;
            bidx_nx  = '0;
            tmr_load = 1'b1;
            tmr_val  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            words_q <= '0;
            nw_q    <= '0;
            widx_q  <= '0;
            bidx_q  <= '0;
            sr_q    <= '0;
            fsync_q <= 1'b1;
            sclk_q  <= 1'b1;
            sdata_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wdone_q <= 1'b0;
        end else begin
            state   <= state_nx;
            words_q <= words_nx;
            nw_q    <= nw_nx;
            widx_q  <= widx_nx;
            bidx_q  <= bidx_nx;
            sr_q    <= sr_nx;
            fsync_q <= fsync_nx;
            sclk_q  <= sclk_nx;
            sdata_q <= sdata_nx;
            busy_q  <= busy_nx;
            done_q  <= done_nx;
            wdone_q <= wdone_nx;
        end
    end

    assign bus.fsync     = fsync_q;
    assign bus.sclk      = sclk_q;
    assign bus.sdata     = sdata_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.word_done = wdone_q;
endmodule
